// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory SRAM arbiter.
// Master indices, state encoding and SRAM field widths.
package dm_arb_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

    typedef logic [3:0] web_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select with a bounded burst.
// Pure combinational; the caller owns all state.
module rr_pick2
    import dm_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic [1:0] req,
    input  arb_state_t state,
    input  logic [3:0] burst_cnt,
    input  logic       last_winner,
    output logic [1:0] winner
);

    localparam logic [3:0] BURST_TOP = 4'(BURST_MAX - 1);

    logic both;
    logic keep;

    // Pick the winner: lone requester, owner burst, or alternate on a tie.
    always_comb begin
        winner = 2'b00;
        both   = &req;
        keep   = burst_cnt < BURST_TOP;
        unique case (1'b1)
            (!both): winner = req;
            (both && state == OWN0): winner = keep ? 2'b01 : 2'b10;
            (both && state == OWN1): winner = keep ? 2'b10 : 2'b01;
            default: winner = last_winner ? 2'b01 : 2'b10;
        endcase
    end

endmodule

// File: rtl/dm_sram_arbiter.sv
// Shares one data-memory SRAM macro between the CPU port and a second master.
// Single-cycle issue, read data returned one cycle later with a per-master valid.
module dm_sram_arbiter #(
    parameter int unsigned ADDR_W    = dm_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W    = dm_arb_pkg::DATA_W,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_i,
    input  logic [1:0][3:0]        we_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   sram_cs_o,
    output logic                   sram_oe_o,
    output logic [3:0]             sram_web_o,
    output logic [ADDR_W-1:0]      sram_a_o,
    output logic [DATA_W-1:0]      sram_di_o,
    input  logic [DATA_W-1:0]      sram_do_i
);

    import dm_arb_pkg::*;

    localparam logic [3:0] BURST_TOP = 4'(BURST_MAX - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic              last_q, last_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] di_q, di_d;

    logic [1:0] pick;
    logic       issue;
    logic       m;
    arb_state_t own_m;

    rr_pick2 #(
        .BURST_MAX(BURST_MAX)
    ) u_pick (
        .req        (req_i),
        .state      (state_q),
        .burst_cnt  (burst_q),
        .last_winner(last_q),
        .winner     (pick)
    );

    // Grant and SRAM drive; no grant can escape while reset is held.
    always_comb begin
        gnt_o      = pick & {2{rst}};
        issue      = |gnt_o;
        m          = gnt_o[1];
        own_m      = m ? OWN1 : OWN0;
        sram_cs_o  = issue;
        sram_a_o   = issue ? addr_i[m] : a_q;
        sram_di_o  = issue ? wdata_i[m] : di_q;
        sram_web_o = issue ? ~we_i[m] : 4'hF;
        sram_oe_o  = rd_pend_q;
        rvalid_o   = rd_pend_q ? (rd_owner_q ? 2'b10 : 2'b01) : 2'b00;
        rdata_o    = rd_pend_q ? sram_do_i : '0;
    end

    // Next ownership, burst count and read-return bookkeeping.
    always_comb begin
        state_d    = IDLE;
        burst_d    = '0;
        last_d     = last_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        a_d        = sram_a_o;
        di_d       = sram_di_o;
        if (issue) begin
            state_d    = own_m;
            last_d     = m;
            rd_pend_d  = (we_i[m] == 4'h0);
            rd_owner_d = m;
            if (state_q == own_m) begin
                burst_d = (burst_q >= BURST_TOP) ? BURST_TOP : burst_q + 4'd1;
            end
        end
    end

    // State registers; reset also kills any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            last_q     <= M1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= M0;
            a_q        <= '0;
            di_q       <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            a_q        <= a_d;
            di_q       <= di_d;
        end
    end

    // A waiting master must hold its request until granted.
    for (genvar g = 0; g < 2; g++) begin : g_hold
        req_hold_a: assert property (@(posedge clk) disable iff (!rst)
            (req_i[g] && !gnt_o[g]) |=> req_i[g]);
    end

endmodule

// File: tb/tb_dm_sram_arbiter.sv
// Directed bench for dm_sram_arbiter with a behavioural SRAM and a read scoreboard.
// Expected read data comes from a reference memory updated on each expected write grant.
module tb_dm_sram_arbiter;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_i = '0;
    logic [1:0][3:0]   we_i = '0;
    logic [1:0][13:0]  addr_i = '0;
    logic [1:0][31:0]  wdata_i = '0;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic              sram_cs_o;
    logic              sram_oe_o;
    logic [3:0]        sram_web_o;
    logic [13:0]       sram_a_o;
    logic [31:0]       sram_di_o;
    logic [31:0]       sram_do = '0;

    dm_sram_arbiter #(
        .ADDR_W(14),
        .DATA_W(32),
        .BURST_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .sram_cs_o (sram_cs_o),
        .sram_oe_o (sram_oe_o),
        .sram_web_o(sram_web_o),
        .sram_a_o  (sram_a_o),
        .sram_di_o (sram_di_o),
        .sram_do_i (sram_do)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: byte-write, registered read.
    logic [31:0] smem [0:16383];
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_web_o == 4'hF) begin
                sram_do <= smem[sram_a_o];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!sram_web_o[b]) smem[sram_a_o][8*b +: 8] <= sram_di_o[8*b +: 8];
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] d;
        int          due;
    } rd_exp_t;

    rd_exp_t     sbq[$];
    logic [31:0] ref_mem [int];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          k0 = 0;
    int          k1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_txn(input int mi, input logic [3:0] we, input logic [13:0] a,
                           input logic [31:0] d);
        we_i[mi]    = we;
        addr_i[mi]  = a;
        wdata_i[mi] = d;
    endtask

    task automatic set_m0(input int k);
        set_txn(0, 4'hF, 14'h100 + 14'(k), 32'hC0DE0000 + 32'(k));
    endtask

    task automatic set_m1(input int k);
        set_txn(1, 4'h0, 14'h100 + 14'(k % 8), 32'h0);
    endtask

    // One cycle: drive req, check returns and the issue at the negedge, advance.
    task automatic step(input logic [1:0] rq, input logic [1:0] eg, input string tag);
        rd_exp_t     e;
        logic        mm;
        logic [3:0]  wn;
        logic [31:0] w;
        int          a;
        req_i = rq;
        @(negedge clk);
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk({tag, "/rvalid"}, 32'(rvalid_o), 32'(e.rv));
            chk({tag, "/rdata"}, rdata_o, e.d);
            chk({tag, "/oe"}, 32'(sram_oe_o), 32'd1);
        end else begin
            chk({tag, "/no_rvalid"}, 32'(rvalid_o), 32'd0);
        end
        chk({tag, "/gnt"}, 32'(gnt_o), 32'(eg));
        if (eg != 2'b00) begin
            mm = eg[1];
            wn = ~we_i[mm];
            a  = int'(addr_i[mm]);
            chk({tag, "/cs"}, 32'(sram_cs_o), 32'd1);
            chk({tag, "/addr"}, 32'(sram_a_o), 32'(addr_i[mm]));
            chk({tag, "/web"}, 32'(sram_web_o), 32'(wn));
            if (we_i[mm] != 4'h0) begin
                chk({tag, "/di"}, sram_di_o, wdata_i[mm]);
                w = ref_mem.exists(a) ? ref_mem[a] : 32'hxxxxxxxx;
                for (int b = 0; b < 4; b++) begin
                    if (we_i[mm][b]) w[8*b +: 8] = wdata_i[mm][8*b +: 8];
                end
                ref_mem[a] = w;
            end else begin
                e.rv  = mm ? 2'b10 : 2'b01;
                e.d   = ref_mem[a];
                e.due = cyc + 1;
                sbq.push_back(e);
            end
        end else begin
            chk({tag, "/cs_idle"}, 32'(sram_cs_o), 32'd0);
            chk({tag, "/web_idle"}, 32'(sram_web_o), 32'hF);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] eg;
        #1 rst = 1'b0;
        req_i = 2'b11;
        set_txn(0, 4'hF, 14'h0010, 32'hDEADBEEF);
        set_txn(1, 4'hF, 14'h0020, 32'h11223344);
        repeat (2) @(posedge clk);
        #1;
        chk("rst/gnt", 32'(gnt_o), 32'd0);
        chk("rst/rvalid", 32'(rvalid_o), 32'd0);
        chk("rst/rdata", rdata_o, 32'd0);
        chk("rst/cs", 32'(sram_cs_o), 32'd0);
        chk("rst/oe", 32'(sram_oe_o), 32'd0);
        chk("rst/web", 32'(sram_web_o), 32'hF);
        chk("rst/a", 32'(sram_a_o), 32'd0);
        chk("rst/di", sram_di_o, 32'd0);
        rst = 1'b1;

        step(2'b11, 2'b01, "first_tie");
        set_txn(0, 4'h0, 14'h0010, 32'h0);
        step(2'b11, 2'b01, "m0_read");
        step(2'b10, 2'b10, "m1_preload");
        set_txn(1, 4'b0100, 14'h0020, 32'hAABBCCDD);
        step(2'b10, 2'b10, "m1_bytewr");
        set_txn(1, 4'h0, 14'h0020, 32'h0);
        step(2'b10, 2'b10, "m1_read");
        step(2'b00, 2'b00, "idle");
        chk("idle/a_hold", 32'(sram_a_o), 32'h20);
        chk("merge_value", ref_mem[32'h20], 32'h11BB3344);

        set_m0(k0);
        set_m1(k1);
        for (int i = 0; i < 12; i++) begin
            eg = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
            step(2'b11, eg, $sformatf("contend%0d", i));
            if (eg[0]) begin
                k0++;
                set_m0(k0);
            end else begin
                k1++;
                set_m1(k1);
            end
        end

        for (int i = 0; i < 11; i++) begin
            step(2'b10, 2'b10, $sformatf("lone%0d", i));
            k1++;
            set_m1(k1);
        end
        step(2'b11, 2'b01, "m0_cuts_in");
        step(2'b10, 2'b10, "m1_resume");
        step(2'b00, 2'b00, "drain");

        set_txn(0, 4'h0, 14'h0010, 32'h0);
        step(2'b01, 2'b01, "pre_rst_read");
        #2 rst = 1'b0;
        #1;
        chk("midrst/rvalid", 32'(rvalid_o), 32'd0);
        chk("midrst/rdata", rdata_o, 32'd0);
        chk("midrst/oe", 32'(sram_oe_o), 32'd0);
        chk("midrst/gnt", 32'(gnt_o), 32'd0);
        req_i = 2'b00;
        sbq.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, $sformatf("post_rst%0d", i));
        step(2'b01, 2'b01, "reread");
        step(2'b00, 2'b00, "reread_ret");
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
